// File: rtl/cnn_pkg.sv
// Constants, types and helpers shared by the CNN streaming datapath blocks.
package cnn_pkg;

  localparam int DATA_WIDTH      = 32;
  localparam int IMAGE_SIZE      = 16*16;
  localparam int CHANNEL_NUM_OUT = 64;
  localparam int FP32_SIGN_BIT   = 31;
  localparam int L_ADD           = 3;

  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  // Leading-zero count of a 27-bit mantissa+GRS word; 27 when the word is zero.
  function automatic logic [4:0] lzc27(input logic [26:0] x);
    logic [4:0] n;
    n = 5'd27;
    for (int unsigned i = 0; i < 27; i++) begin
      if (x[i]) n = 5'(26 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/fp_add_sub.sv
// Three-stage FP32 adder/subtractor, round-to-nearest-even, subnormals supported.
module fp_add_sub import cnn_pkg::*; (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        sub,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        valid_out
);

  fp32_t       fa, fb;
  logic [7:0]  ea, eb;
  logic [23:0] ma, mb;
  logic        a_nan, b_nan, a_inf, b_inf, a_big;

  always_comb begin
    fa      = a;
    fb      = b;
    fb.sign = b[31] ^ sub;
    ea      = (fa.exp == '0) ? 8'd1 : fa.exp;
    eb      = (fb.exp == '0) ? 8'd1 : fb.exp;
    ma      = {fa.exp != '0, fa.frac};
    mb      = {fb.exp != '0, fb.frac};
    a_nan   = (fa.exp == '1) && (fa.frac != '0);
    b_nan   = (fb.exp == '1) && (fb.frac != '0);
    a_inf   = (fa.exp == '1) && (fa.frac == '0);
    b_inf   = (fb.exp == '1) && (fb.frac == '0);
    a_big   = (a[30:0] >= b[30:0]);
  end

  logic        s1_valid, s1_sign, s1_eff_sub, s1_special;
  logic [7:0]  s1_exp, s1_diff;
  logic [23:0] s1_big_m, s1_small_m;
  logic [31:0] s1_spec_val;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid    <= 1'b0;
      s1_sign     <= 1'b0;
      s1_eff_sub  <= 1'b0;
      s1_special  <= 1'b0;
      s1_exp      <= '0;
      s1_diff     <= '0;
      s1_big_m    <= '0;
      s1_small_m  <= '0;
      s1_spec_val <= '0;
    end else begin
      s1_valid   <= valid_in;
      s1_eff_sub <= fa.sign ^ fb.sign;
      if (a_big) begin
        s1_sign    <= fa.sign;
        s1_exp     <= ea;
        s1_big_m   <= ma;
        s1_small_m <= mb;
        s1_diff    <= ea - eb;
      end else begin
        s1_sign    <= fb.sign;
        s1_exp     <= eb;
        s1_big_m   <= mb;
        s1_small_m <= ma;
        s1_diff    <= eb - ea;
      end
      s1_special <= a_nan | b_nan | a_inf | b_inf;
      if (a_nan || b_nan || (a_inf && b_inf && (fa.sign != fb.sign)))
        s1_spec_val <= FP32_QNAN;
      else if (a_inf)
        s1_spec_val <= a;
      else
        s1_spec_val <= fb;
    end
  end

  logic [26:0] big_ext, small_ext, shifted, lost_mask, aligned;

  // Alignment keeps guard/round bits and folds everything shifted out into sticky.
  always_comb begin
    big_ext   = {s1_big_m, 3'b000};
    small_ext = {s1_small_m, 3'b000};
    shifted   = '0;
    lost_mask = '0;
    if (s1_diff >= 8'd27) begin
      aligned = {26'd0, |s1_small_m};
    end else begin
      shifted   = small_ext >> s1_diff;
      lost_mask = (27'd1 << s1_diff) - 27'd1;
      aligned   = {shifted[26:1], shifted[0] | (|(small_ext & lost_mask))};
    end
  end

  logic        s2_valid, s2_sign, s2_eff_sub, s2_special;
  logic [7:0]  s2_exp;
  logic [27:0] s2_sum;
  logic [31:0] s2_spec_val;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s2_valid    <= 1'b0;
      s2_sign     <= 1'b0;
      s2_eff_sub  <= 1'b0;
      s2_special  <= 1'b0;
      s2_exp      <= '0;
      s2_sum      <= '0;
      s2_spec_val <= '0;
    end else begin
      s2_valid    <= s1_valid;
      s2_sign     <= s1_sign;
      s2_eff_sub  <= s1_eff_sub;
      s2_special  <= s1_special;
      s2_exp      <= s1_exp;
      s2_spec_val <= s1_spec_val;
      s2_sum      <= s1_eff_sub ? ({1'b0, big_ext} - {1'b0, aligned})
                                : ({1'b0, big_ext} + {1'b0, aligned});
    end
  end

  logic [4:0]  lz;
  logic [7:0]  sh;
  logic [26:0] m27;
  logic [9:0]  e_norm;
  logic        round_up;
  logic [30:0] packed_mag;
  logic [31:0] res;

  // Left shift is clamped so the exponent never drops below the subnormal floor;
  // the rounding increment is added across exponent+fraction so carries propagate.
  always_comb begin
    lz = lzc27(s2_sum[26:0]);
    sh = '0;
    if (s2_sum[27]) begin
      m27    = {s2_sum[27:2], s2_sum[1] | s2_sum[0]};
      e_norm = {2'b00, s2_exp} + 10'd1;
    end else begin
      if ({3'b000, lz} < (s2_exp - 8'd1)) sh = {3'b000, lz};
      else                                sh = s2_exp - 8'd1;
      m27    = s2_sum[26:0] << sh;
      e_norm = m27[26] ? {2'b00, 8'(s2_exp - sh)} : 10'd0;
    end
    round_up   = m27[2] & (m27[1] | m27[0] | m27[3]);
    packed_mag = {e_norm[7:0], m27[25:3]} + {30'd0, round_up};
    if (s2_special)
      res = s2_spec_val;
    else if (s2_sum == '0)
      res = {s2_sign & ~s2_eff_sub, 31'd0};
    else if ((e_norm >= 10'd255) || (packed_mag[30:23] == 8'hFF))
      res = {s2_sign, 8'hFF, 23'd0};
    else
      res = {s2_sign, packed_mag};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      result    <= '0;
      valid_out <= 1'b0;
    end else begin
      result    <= res;
      valid_out <= s2_valid;
    end
  end

endmodule

// File: rtl/relu_fp32.sv
// Registered FP32 ReLU: any word with the sign bit set (incl. -0.0, -NaN) becomes +0.
module relu_fp32 import cnn_pkg::FP32_ZERO, cnn_pkg::FP32_SIGN_BIT; #(
  parameter int DATA_WIDTH = 32,
  parameter int RELU_EN    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      pxl_out   <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (!valid_in || ((RELU_EN != 0) && pxl_in[FP32_SIGN_BIT]))
        pxl_out <= DATA_WIDTH'(FP32_ZERO);
      else
        pxl_out <= pxl_in;
    end
  end

endmodule

// File: rtl/conv_bias_relu_stream.sv
// Adds a per-output-channel FP32 bias to the accumulated pixel stream, applies
// optional ReLU and tags channel/frame boundaries.
module conv_bias_relu_stream #(
  parameter int DATA_WIDTH      = cnn_pkg::DATA_WIDTH,
  parameter int IMAGE_SIZE      = cnn_pkg::IMAGE_SIZE,
  parameter int CHANNEL_NUM_OUT = cnn_pkg::CHANNEL_NUM_OUT,
  parameter int RELU_EN         = 1,
  parameter int POINTER_WIDTH   = $clog2(IMAGE_SIZE) + 1,
  parameter int CH_WIDTH        = $clog2(CHANNEL_NUM_OUT) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  input  logic                  bias_wr_en,
  input  logic [CH_WIDTH-1:0]   bias_addr,
  input  logic [DATA_WIDTH-1:0] bias_data,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out,
  output logic                  last_pxl,
  output logic                  last_frame
);

  localparam int IDX_W = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1;
  localparam logic [POINTER_WIDTH-1:0] PIX_LAST = POINTER_WIDTH'(IMAGE_SIZE - 1);
  localparam logic [CH_WIDTH-1:0]      CH_LAST  = CH_WIDTH'(CHANNEL_NUM_OUT - 1);
  localparam logic [CH_WIDTH-1:0]      CH_COUNT = CH_WIDTH'(CHANNEL_NUM_OUT);

  logic [DATA_WIDTH-1:0]    bias_rf [CHANNEL_NUM_OUT];
  logic [DATA_WIDTH-1:0]    bias_cur, bias_sel, op_bias;
  logic [POINTER_WIDTH-1:0] in_pix, out_pix;
  logic [CH_WIDTH-1:0]      in_ch, out_ch;
  logic                     bias_hit, bias_wr_ok;

  logic                     s0_valid;
  logic [DATA_WIDTH-1:0]    s0_pxl, s0_bias;
  logic                     add_valid;
  logic [DATA_WIDTH-1:0]    add_result;

  // A write landing on the channel being opened this cycle is forwarded directly.
  always_comb begin
    bias_wr_ok = bias_wr_en && (bias_addr < CH_COUNT);
    bias_hit   = bias_wr_en && (bias_addr == in_ch);
    bias_sel   = bias_hit ? bias_data : bias_rf[in_ch[IDX_W-1:0]];
    op_bias    = (in_pix == '0) ? bias_sel : bias_cur;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < CHANNEL_NUM_OUT; i++) bias_rf[i] <= '0;
    end else if (bias_wr_ok) begin
      bias_rf[bias_addr[IDX_W-1:0]] <= bias_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      in_pix   <= '0;
      in_ch    <= '0;
      bias_cur <= '0;
      s0_valid <= 1'b0;
      s0_pxl   <= '0;
      s0_bias  <= '0;
    end else begin
      s0_valid <= valid_in;
      if (valid_in) begin
        s0_pxl  <= pxl_in;
        s0_bias <= op_bias;
        if (in_pix == '0) bias_cur <= bias_sel;
        if (in_pix == PIX_LAST) begin
          in_pix <= '0;
          in_ch  <= (in_ch == CH_LAST) ? '0 : in_ch + 1'b1;
        end else begin
          in_pix <= in_pix + 1'b1;
        end
      end
    end
  end

  fp_add_sub u_add (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (s0_valid),
    .sub       (1'b0),
    .a         (s0_pxl),
    .b         (s0_bias),
    .result    (add_result),
    .valid_out (add_valid)
  );

  relu_fp32 #(
    .DATA_WIDTH (DATA_WIDTH),
    .RELU_EN    (RELU_EN)
  ) u_relu (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (add_valid),
    .pxl_in    (add_result),
    .pxl_out   (pxl_out),
    .valid_out (valid_out)
  );

  // Output-side counters track the adder's valid so tags stay aligned with the data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_pix    <= '0;
      out_ch     <= '0;
      last_pxl   <= 1'b0;
      last_frame <= 1'b0;
    end else begin
      last_pxl   <= add_valid && (out_pix == PIX_LAST);
      last_frame <= add_valid && (out_pix == PIX_LAST) && (out_ch == CH_LAST);
      if (add_valid) begin
        if (out_pix == PIX_LAST) begin
          out_pix <= '0;
          out_ch  <= (out_ch == CH_LAST) ? '0 : out_ch + 1'b1;
        end else begin
          out_pix <= out_pix + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_bias_relu_stream.sv
// Directed bench: 4-pixel, 2-channel frames through ReLU-on and ReLU-off instances.
module tb_conv_bias_relu_stream;

  localparam int IS  = 4;
  localparam int CN  = 2;
  localparam int DW  = 32;
  localparam int CW  = $clog2(CN) + 1;
  localparam int LAT = cnn_pkg::L_ADD + 2;

  localparam logic [31:0] HALF  = 32'h3F00_0000;
  localparam logic [31:0] ONE   = 32'h3F80_0000;
  localparam logic [31:0] ONE5  = 32'h3FC0_0000;
  localparam logic [31:0] TWO   = 32'h4000_0000;
  localparam logic [31:0] TWO5  = 32'h4020_0000;
  localparam logic [31:0] THREE = 32'h4040_0000;
  localparam logic [31:0] THR5  = 32'h4060_0000;
  localparam logic [31:0] TEN   = 32'h4120_0000;
  localparam logic [31:0] M1    = 32'hBF80_0000;
  localparam logic [31:0] M2    = 32'hC000_0000;
  localparam logic [31:0] NZERO = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          reset, valid_in, bias_wr_en;
  logic [DW-1:0] pxl_in, bias_data;
  logic [CW-1:0] bias_addr;
  logic [DW-1:0] pxl_out, pxl_out_nr;
  logic          valid_out, valid_out_nr, last_pxl, last_pxl_nr, last_frame, last_frame_nr;

  always #5 clk = ~clk;

  conv_bias_relu_stream #(.IMAGE_SIZE(IS), .CHANNEL_NUM_OUT(CN), .RELU_EN(1)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
    .bias_wr_en(bias_wr_en), .bias_addr(bias_addr), .bias_data(bias_data),
    .pxl_out(pxl_out), .valid_out(valid_out), .last_pxl(last_pxl), .last_frame(last_frame)
  );

  conv_bias_relu_stream #(.IMAGE_SIZE(IS), .CHANNEL_NUM_OUT(CN), .RELU_EN(0)) dut_nr (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
    .bias_wr_en(bias_wr_en), .bias_addr(bias_addr), .bias_data(bias_data),
    .pxl_out(pxl_out_nr), .valid_out(valid_out_nr), .last_pxl(last_pxl_nr),
    .last_frame(last_frame_nr)
  );

  typedef struct {
    int          due;
    logic [31:0] px;
    logic [31:0] px_nr;
    logic        lp;
    logic        lf;
  } exp_t;

  exp_t expq[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #1;
    if (valid_out) begin
      if (expq.size() == 0) begin
        chk("spurious_valid", 32'(valid_out), 32'd0);
      end else begin
        e = expq.pop_front();
        chk("latency", cyc, e.due);
        chk("pxl_out", pxl_out, e.px);
        chk("pxl_out_norelu", pxl_out_nr, e.px_nr);
        chk("valid_out_norelu", 32'(valid_out_nr), 32'd1);
        chk("last_pxl", 32'({last_pxl, last_pxl_nr}), 32'({e.lp, e.lp}));
        chk("last_frame", 32'({last_frame, last_frame_nr}), 32'({e.lf, e.lf}));
      end
    end else begin
      chk("idle_pxl_zero", pxl_out | pxl_out_nr, 32'd0);
      chk("idle_flags", 32'({valid_out_nr, last_pxl, last_frame}), 32'd0);
      if (expq.size() != 0 && expq[0].due <= cyc) begin
        e = expq.pop_front();
        chk("missing_valid", 32'(valid_out), 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] p, input logic w,
                       input logic [CW-1:0] a, input logic [31:0] d);
    tick();
    valid_in   = v;
    pxl_in     = v ? p : '0;
    bias_wr_en = w;
    bias_addr  = a;
    bias_data  = d;
  endtask

  task automatic expect_px(input logic [31:0] px, input logic [31:0] px_nr,
                           input logic lp, input logic lf);
    exp_t e;
    e.due   = cyc + LAT;
    e.px    = px;
    e.px_nr = px_nr;
    e.lp    = lp;
    e.lf    = lf;
    expq.push_back(e);
  endtask

  task automatic send(input logic [31:0] p, input logic [31:0] px, input logic [31:0] px_nr,
                      input logic lp, input logic lf);
    drive(1'b1, p, 1'b0, '0, '0);
    expect_px(px, px_nr, lp, lf);
  endtask

  task automatic send_wr(input logic [31:0] p, input logic [CW-1:0] a, input logic [31:0] d,
                         input logic [31:0] px, input logic [31:0] px_nr,
                         input logic lp, input logic lf);
    drive(1'b1, p, 1'b1, a, d);
    expect_px(px, px_nr, lp, lf);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic gap();
    idle(int'($urandom_range(0, 2)));
  endtask

  initial begin
    reset = 1'b0; valid_in = 1'b0; pxl_in = '0;
    bias_wr_en = 1'b0; bias_addr = '0; bias_data = '0;
    idle(3);
    chk("rst_pxl_out", pxl_out, 32'd0);
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_last_pxl", 32'(last_pxl), 32'd0);
    chk("rst_last_frame", 32'(last_frame), 32'd0);
    reset = 1'b1;

    drive(1'b0, '0, 1'b1, 2'd0, ONE);
    drive(1'b0, '0, 1'b1, 2'd2, TEN);
    idle(1);

    // frame 1, ch0: bias 1.0
    send(HALF, ONE5, ONE5, 1'b0, 1'b0); gap();
    send(M2,   32'd0, M1,  1'b0, 1'b0); gap();
    send(HALF, ONE5, ONE5, 1'b0, 1'b0); gap();
    send(HALF, ONE5, ONE5, 1'b1, 1'b0); gap();
    // frame 1, ch1: same-cycle bypass 2.0, then a mid-channel write of 3.0
    send_wr(HALF, 2'd1, TWO,   TWO5, TWO5, 1'b0, 1'b0); gap();
    send_wr(HALF, 2'd1, THREE, TWO5, TWO5, 1'b0, 1'b0); gap();
    send(HALF, TWO5, TWO5, 1'b0, 1'b0); gap();
    send(HALF, TWO5, TWO5, 1'b1, 1'b1); gap();

    // frame 2: ch0 wraps to bias[0]; a mid-ch0 write of -0.0 waits for frame 3
    send(HALF, ONE5, ONE5, 1'b0, 1'b0); gap();
    send(HALF, ONE5, ONE5, 1'b0, 1'b0); gap();
    send_wr(HALF, 2'd0, NZERO, ONE5, ONE5, 1'b0, 1'b0); gap();
    send(HALF, ONE5, ONE5, 1'b1, 1'b0); gap();
    send(HALF, THR5, THR5, 1'b0, 1'b0); gap();
    send(HALF, THR5, THR5, 1'b0, 1'b0); gap();
    send(HALF, THR5, THR5, 1'b0, 1'b0); gap();
    send(HALF, THR5, THR5, 1'b1, 1'b1); gap();

    // frame 3, ch0: -0.0 + -0.0 is rectified to +0
    send(NZERO, 32'd0, NZERO, 1'b0, 1'b0);
    send(HALF,  HALF,  HALF,  1'b0, 1'b0);
    idle(LAT + 2);
    chk("drain_before_reset", expq.size(), 32'd0);

    // three pixels in flight, then reset; none of them may emerge
    drive(1'b1, HALF, 1'b0, '0, '0);
    drive(1'b1, HALF, 1'b0, '0, '0);
    drive(1'b1, HALF, 1'b0, '0, '0);
    tick();
    reset = 1'b0; valid_in = 1'b0;
    idle(1);
    tick();
    reset = 1'b1;
    tick();
    chk("valid_after_reset", 32'(valid_out), 32'd0);

    // counters restart at ch0 pixel 0 and the cleared regfile gives bias 0
    send(HALF, HALF, HALF, 1'b0, 1'b0);
    send(HALF, HALF, HALF, 1'b0, 1'b0);
    send(HALF, HALF, HALF, 1'b0, 1'b0);
    send(HALF, HALF, HALF, 1'b1, 1'b0);
    idle(LAT + 3);
    chk("final_drain", expq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/conv_bias_relu_stream.md
Name: conv_bias_relu_stream

Overview:
- Downstream neighbour of the channel-input accumulator. It consumes the accumulated per-output-channel feature-map stream and adds a per-output-channel FP32 bias.
- It then applies an optional ReLU and tags each pixel with channel and frame boundary flags.
- Output feeds the next layer's line buffer/FIFO. Bias values are loaded through a small register-file write port.

Parameters:
- DATA_WIDTH, 32, IEEE-754 single word width.
- IMAGE_SIZE, 16*16, pixels per output channel.
- CHANNEL_NUM_OUT, 64, output channels per frame.
- RELU_EN, 1, 1 = apply ReLU, 0 = pass the biased value through.
- POINTER_WIDTH, $clog2(IMAGE_SIZE)+1, pixel counter width.
- CH_WIDTH, $clog2(CHANNEL_NUM_OUT)+1, channel counter/address width.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-low; reset==0 on a clk edge resets the block.
- valid_in  in  1  pxl_in qualifier, one pixel per asserted cycle.
- pxl_in  in  DATA_WIDTH  accumulated pixel, channel-major, raster within a channel.
- bias_wr_en  in  1  bias register-file write strobe.
- bias_addr  in  CH_WIDTH  bias channel index, 0..CHANNEL_NUM_OUT-1.
- bias_data  in  DATA_WIDTH  FP32 bias value.
- pxl_out  out  DATA_WIDTH  biased, optionally rectified pixel.
- valid_out  out  1  pxl_out qualifier.
- last_pxl  out  1  pulses with the last pixel of a channel.
- last_frame  out  1  pulses with the last pixel of the last channel.

Behaviour:
- Reset:
  - pxl_out=0, valid_out=0, last_pxl=0, last_frame=0.
  - All counters are 0; bias_cur=0; the bias register file is cleared to 0.
  - The fp_add_sub pipeline is flushed via its reset.
- Input counters, advanced on valid_in only:
  - in_pix counts 0..IMAGE_SIZE-1 and wraps to 0.
  - in_ch increments on an in_pix wrap and counts 0..CHANNEL_NUM_OUT-1, wrapping to 0.
  - Gaps in valid_in are allowed; counters hold during gaps.
- Bias selection:
  - When valid_in is high and in_pix==0, bias_cur <= regfile[in_ch].
  - If bias_wr_en is set with bias_addr==in_ch in that same cycle, bias_cur takes bias_data (write bypass).
  - Writes at any other time update only the regfile. A mid-channel write to the active channel does not affect the current channel; it takes effect from that channel's next frame.
  - bias_addr >= CHANNEL_NUM_OUT: the write is ignored.
- Stage 0 (input register):
  - valid_in and pxl_in are registered.
  - The operand bias is the bypassed value for in_pix==0, otherwise bias_cur.
- Stage 1 (add): fp_add_sub instance with a = pixel, b = bias, valid_in = stage-0 valid. Its latency is L_ADD (fixed by the codebase fp_add_sub).
- Stage 2 (ReLU register):
  - If RELU_EN and sign bit = 1, pxl_out = 0x00000000; this includes -0.0.
  - Otherwise pxl_out = the adder result.
  - valid_out = the adder valid_out, registered. When valid_out=0, pxl_out = 0.
- Total latency: valid_in to valid_out = L_ADD + 2 cycles. Throughput is 1 pixel/cycle with no backpressure; the downstream stage must always accept.
- Output counters, advanced on the adder valid_out only (stays aligned regardless of L_ADD):
  - out_pix and out_ch mirror the input counters.
  - last_pxl is registered with pxl_out when out_pix==IMAGE_SIZE-1.
  - last_frame additionally requires out_ch==CHANNEL_NUM_OUT-1.
  - Both counters wrap to 0 after last_frame.
- Reset mid-operation: in-flight pixels are discarded, and no valid_out occurs in the cycle after reset deasserts. The regfile is cleared, so biases must be reloaded.
- NaN/Inf: passed as produced by fp_add_sub. ReLU tests only the sign bit, so a negative NaN becomes 0.

Decomposition:
- Shared package (cnn_pkg): DATA_WIDTH, FP32_ZERO=32'h0, FP32_SIGN_BIT=31, and the channel/size constants shared with the accumulator.
- One natural sub-module: relu_fp32 (registered sign-test mux with valid, RELU_EN bypass).
- fp_add_sub is reused as-is.

Test Plan:
- Pixel with bias:
  - Reset, then load bias[0]=0x3F800000 (1.0).
  - Stream ch0 pixels 0x3F000000 (0.5).
  - Expected: pxl_out=0x3FC00000 (1.5) exactly L_ADD+2 cycles after each input.
- ReLU and sign bit:
  - Use bias[0]=0x3F800000 with pixel 0xC0000000 (-2.0). Expected: with RELU_EN=1, pxl_out=0x00000000; with RELU_EN=0, pxl_out=0xBF800000.
  - Separately, pixel 0x80000000 with bias 0x80000000. Expected: output 0x00000000.
- Boundaries, with IMAGE_SIZE=4 and CHANNEL_NUM_OUT=2:
  - Stream 8 pixels with random valid_in gaps.
  - Expected: last_pxl on outputs 4 and 8; last_frame only on output 8; counters wrap, so the 9th pixel uses bias[0].
- Bias write timing:
  - Write bias[1]=0x40000000 in the same cycle as ch1 pixel 0. Expected: the whole of ch1 uses 2.0.
  - Write bias[1]=0x40400000 mid-ch1. Expected: the current ch1 is unchanged; the next frame's ch1 uses 3.0.
- Reset mid-stream:
  - Assert reset (0) while 3 pixels are in flight.
  - Expected: no valid_out after reset; counters restart, so the first post-reset pixel is ch0 pixel 0 with bias 0.
